// File: rtl/data_types.sv
// data_types: shared word type and default queue depth
package data_types;
  typedef logic [31:0] word32_t;
  localparam int IQ_DEPTH_DEFAULT = 8;
endpackage

// File: rtl/iq_storage.sv
// iq_storage: DEPTH x word32_t register array, one synchronous write port and one asynchronous read port, no reset
module iq_storage
  import data_types::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  word32_t                  i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output word32_t                  o_rdata
);
  word32_t r_mem [DEPTH];
  // store the incoming word at the write index; contents persist across reset and flush
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instr_queue.sv
// instr_queue: circular instruction queue between fetch and dispatch; define IQ_COUNT_EN to add the count_o occupancy port
module instr_queue
  import data_types::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   iq_write_i,
  input  word32_t                instr_i,
  output logic                   iq_full_o,
  input  logic                   iq_read_i,
  output word32_t                instr_o,
  output logic                   iq_valid_o,
  input  logic                   flush_i
`ifdef IQ_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] count_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wptr, r_rptr;
  logic        w_wr, w_rd;
  assign iq_valid_o = r_wptr != r_rptr;
  assign iq_full_o  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_wr       = iq_write_i & ~iq_full_o & ~flush_i;
  assign w_rd       = iq_read_i & iq_valid_o & ~flush_i;
`ifdef IQ_COUNT_EN
  assign count_o = r_wptr - r_rptr;
`endif
  // pointer update: flush wins over a same-cycle read or write
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= flush_i ? '0 : (w_wr ? r_wptr + 1'b1 : r_wptr);
      r_rptr <= flush_i ? '0 : (w_rd ? r_rptr + 1'b1 : r_rptr);
    end
  iq_storage #(.DEPTH(DEPTH)) u_storage (
    .i_clk  (clk_i),
    .i_we   (w_wr),
    .i_waddr(r_wptr[AW-1:0]),
    .i_wdata(instr_i),
    .i_raddr(r_rptr[AW-1:0]),
    .o_rdata(instr_o)
  );
endmodule
